// File: rtl/siw_memory_bram_1_arb_pkg.sv
// Shared types and constants for the SIW BRAM port-A access controller.
package siw_memory_bram_1_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned RD_LAT_DEF = 3;

    localparam logic       ID_R0    = 1'b0;
    localparam logic       ID_R1    = 1'b1;
    localparam logic [1:0] MEM_CONF = 2'd0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // One slot of the read-return tag pipe.
    typedef struct packed {
        logic vld;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/siw_rr_arb2.sv
// Two-way round-robin arbiter; grant_c is combinational, pointer moves only on a grant.
module siw_rr_arb2 (
    input  logic       siw_memory_bram_1_clk_a,
    input  logic       siw_memory_bram_1_reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant_c
);

    // last_q = 1 means r1 was granted last, so r0 wins the next tie.
    logic last_q;
    logic last_d;

    always_comb begin
        grant_c = 2'b00;
        last_d  = last_q;
        if (advance) begin
            case (valid)
                2'b01:   grant_c = 2'b01;
                2'b10:   grant_c = 2'b10;
                2'b11:   grant_c = last_q ? 2'b01 : 2'b10;
                default: grant_c = 2'b00;
            endcase
        end
        if (grant_c[0]) begin
            last_d = 1'b0;
        end else if (grant_c[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge siw_memory_bram_1_clk_a or posedge siw_memory_bram_1_reset) begin
        if (siw_memory_bram_1_reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/siw_memory_bram_1_arb_a.sv
// Port-A controller: round-robin sharing of BRAM port A, read-return tagging and memory clear.
module siw_memory_bram_1_arb_a
    import siw_memory_bram_1_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned RD_LAT      = RD_LAT_DEF,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              siw_memory_bram_1_clk_a,
    input  logic              siw_memory_bram_1_reset,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_enable_a,
    output logic              mem_write_en_a,
    output logic [ADDR_W-1:0] mem_address_a,
    output logic [DATA_W-1:0] mem_input_data_a,
    output logic [1:0]        mem_conf_a,
    output logic              mem_init,
    input  logic [DATA_W-1:0] mem_output_data_a
);

    state_e                     state_q, state_d;
    logic [ADDR_W-1:0]          cnt_q, cnt_d;
    logic                       en_q, en_d;
    logic                       we_q, we_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]          wdata_q, wdata_d;
    logic                       done_q, done_d;
    rd_tag_t [RD_LAT-1:0]       tag_q, tag_d;
    rd_tag_t                    push;
    logic [1:0]                 gnt;

    siw_rr_arb2 u_arb (
        .siw_memory_bram_1_clk_a (siw_memory_bram_1_clk_a),
        .siw_memory_bram_1_reset (siw_memory_bram_1_reset),
        .valid                   ({r1_valid, r0_valid}),
        .advance                 (state_q == ST_RUN),
        .grant_c                 (gnt)
    );

    // Next-state, port register and tag-pipe input.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        push    = '0;
        case (state_q)
            ST_RUN: begin
                if (gnt != 2'b00) begin
                    en_d     = 1'b1;
                    we_d     = gnt[1] ? r1_we    : r0_we;
                    addr_d   = gnt[1] ? r1_addr  : r0_addr;
                    wdata_d  = gnt[1] ? r1_wdata : r0_wdata;
                    push.vld = ~(gnt[1] ? r1_we : r0_we);
                    push.id  = gnt[1] ? ID_R1 : ID_R0;
                end
                if (clear_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                en_d    = 1'b1;
                we_d    = 1'b1;
                addr_d  = cnt_q;
                wdata_d = CLEAR_VALUE;
                cnt_d   = cnt_q + ADDR_W'(1);
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
        endcase
        tag_d = {tag_q[RD_LAT-2:0], push};
    end

    always_ff @(posedge siw_memory_bram_1_clk_a or posedge siw_memory_bram_1_reset) begin
        if (siw_memory_bram_1_reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            tag_q   <= tag_d;
        end
    end

    assign r0_ready         = gnt[0];
    assign r1_ready         = gnt[1];
    assign clear_busy       = (state_q == ST_CLEAR);
    assign clear_done       = done_q;
    assign mem_init         = (state_q == ST_CLEAR);
    assign mem_conf_a       = MEM_CONF;
    assign mem_enable_a     = en_q;
    assign mem_write_en_a   = we_q;
    assign mem_address_a    = addr_q;
    assign mem_input_data_a = wdata_q;
    // Read data is broadcast; only the owner's rvalid qualifies it.
    assign r0_rvalid        = tag_q[RD_LAT-1].vld && (tag_q[RD_LAT-1].id == ID_R0);
    assign r1_rvalid        = tag_q[RD_LAT-1].vld && (tag_q[RD_LAT-1].id == ID_R1);
    assign r0_rdata         = mem_output_data_a;
    assign r1_rdata         = mem_output_data_a;

endmodule

// File: tb/tb_siw_memory_bram_1_arb_a.sv
// Bench for siw_memory_bram_1_arb_a: BRAM model plus a transaction-level scoreboard.
module tb_siw_memory_bram_1_arb_a;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic        busy, done;
    logic        v0 = 1'b0, v1 = 1'b0, w0 = 1'b0, w1 = 1'b0;
    logic [9:0]  a0 = '0, a1 = '0;
    logic [31:0] d0 = '0, d1 = '0;
    logic        rdy0, rdy1, rv0, rv1;
    logic [31:0] rd0, rd1;
    logic        men, mwe, minit;
    logic [9:0]  maddr;
    logic [31:0] mdin, mdout;
    logic [1:0]  mconf;

    always #5 clk = ~clk;

    siw_memory_bram_1_arb_a dut (
        .siw_memory_bram_1_clk_a (clk),
        .siw_memory_bram_1_reset (rst),
        .clear_start       (cs),
        .clear_busy        (busy),
        .clear_done        (done),
        .r0_valid          (v0),
        .r0_ready          (rdy0),
        .r0_we             (w0),
        .r0_addr           (a0),
        .r0_wdata          (d0),
        .r0_rvalid         (rv0),
        .r0_rdata          (rd0),
        .r1_valid          (v1),
        .r1_ready          (rdy1),
        .r1_we             (w1),
        .r1_addr           (a1),
        .r1_wdata          (d1),
        .r1_rvalid         (rv1),
        .r1_rdata          (rd1),
        .mem_enable_a      (men),
        .mem_write_en_a    (mwe),
        .mem_address_a     (maddr),
        .mem_input_data_a  (mdin),
        .mem_conf_a        (mconf),
        .mem_init          (minit),
        .mem_output_data_a (mdout)
    );

    // BRAM: array read stage then output register, writes take effect at once.
    logic [31:0] bram [1024];
    logic [31:0] b_s1 = '0;
    logic [31:0] b_out = '0;
    always @(posedge clk) begin
        if (men) begin
            if (mwe) bram[maddr] <= mdin;
            else     b_s1 <= bram[maddr];
        end
        b_out <= b_s1;
    end
    assign mdout = b_out;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } resp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] exp_mem [1024];
    resp_t       rq [$];
    int          glog [$];
    logic        last_gnt = 1'b1;
    int          busy_rem = 0;
    logic        done_pend = 1'b0;
    logic        en_pend = 1'b0, we_pend = 1'b0;
    logic [9:0]  addr_pend = '0;
    logic [31:0] data_pend = '0;
    logic        acc0, acc1;
    int          busy_cnt, done_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs mid-cycle against the model, then advance the model.
    task automatic tick();
        logic g0, g1, e0, e1, id, we;
        logic [9:0]  a;
        logic [31:0] d;
        @(negedge clk);
        cyc++;
        g0 = 1'b0; g1 = 1'b0;
        if (busy_rem == 0) begin
            if (v0 && v1) begin
                g0 = last_gnt; g1 = ~last_gnt;
            end else begin
                g0 = v0; g1 = v1;
            end
        end
        chk("r0_ready", rdy0, g0);
        chk("r1_ready", rdy1, g1);
        chk("clear_busy", busy, busy_rem != 0);
        chk("mem_init", minit, busy_rem != 0);
        chk("clear_done", done, done_pend);
        chk("mem_enable_a", men, en_pend);
        if (en_pend) begin
            chk("mem_write_en_a", mwe, we_pend);
            chk("mem_address_a", maddr, addr_pend);
            if (we_pend) chk("mem_input_data_a", mdin, data_pend);
        end
        e0 = 1'b0; e1 = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].id) begin
                e1 = 1'b1; chk("r1_rdata", rd1, rq[0].data);
            end else begin
                e0 = 1'b1; chk("r0_rdata", rd0, rq[0].data);
            end
            void'(rq.pop_front());
        end
        chk("r0_rvalid", rv0, e0);
        chk("r1_rvalid", rv1, e1);
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        acc0 = g0; acc1 = g1;
        en_pend = 1'b0; we_pend = 1'b0;
        if (g0 || g1) begin
            id = g1;
            we = id ? w1 : w0;
            a  = id ? a1 : a0;
            d  = id ? d1 : d0;
            last_gnt = id;
            glog.push_back(int'(id));
            en_pend = 1'b1; we_pend = we; addr_pend = a; data_pend = d;
            if (we) exp_mem[a] = d;
            else    rq.push_back('{id: id, data: exp_mem[a], due: cyc + 3});
        end
        done_pend = (busy_rem == 1);
        if (busy_rem != 0) begin
            en_pend = 1'b1; we_pend = 1'b1;
            addr_pend = 10'(1024 - busy_rem); data_pend = 32'd0;
            busy_rem--;
        end else if (cs) begin
            busy_rem = 1024;
            for (int i = 0; i < 1024; i++) exp_mem[i] = 32'd0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Issue one request and wait (bounded) for its acceptance.
    task automatic req(input logic id, input logic we, input logic [9:0] a, input logic [31:0] d);
        int n;
        logic got;
        if (id) begin v1 = 1'b1; w1 = we; a1 = a; d1 = d; end
        else    begin v0 = 1'b1; w0 = we; a0 = a; d0 = d; end
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            got = id ? acc1 : acc0;
            n++;
        end
        if (!got) chk("req_timeout", 32'd0, 32'd1);
        if (id) v1 = 1'b0; else v0 = 1'b0;
    endtask

    task automatic do_reset();
        v0 = 1'b0; v1 = 1'b0; cs = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_r0_ready", rdy0, 1'b0);
        chk("rst_r1_ready", rdy1, 1'b0);
        chk("rst_r0_rvalid", rv0, 1'b0);
        chk("rst_r1_rvalid", rv1, 1'b0);
        chk("rst_clear_busy", busy, 1'b0);
        chk("rst_clear_done", done, 1'b0);
        chk("rst_mem_enable_a", men, 1'b0);
        chk("rst_mem_write_en_a", mwe, 1'b0);
        chk("rst_mem_address_a", maddr, 32'd0);
        chk("rst_mem_input_data_a", mdin, 32'd0);
        chk("rst_mem_init", minit, 1'b0);
        chk("rst_mem_conf_a", mconf, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rq.delete();
        last_gnt = 1'b1; busy_rem = 0; done_pend = 1'b0;
        en_pend = 1'b0; we_pend = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            bram[i] = 32'd0;
            exp_mem[i] = 32'd0;
        end
        do_reset();
        idle(2);

        // Write then read back through r0.
        req(1'b0, 1'b1, 10'd5, 32'hDEADBEEF);
        req(1'b0, 1'b0, 10'd5, 32'd0);
        idle(4);

        // Both requesters holding reads: grants must alternate starting with r0.
        req(1'b0, 1'b1, 10'd1, 32'hA1A1A1A1);
        req(1'b1, 1'b1, 10'd2, 32'hB2B2B2B2);
        glog.delete();
        v0 = 1'b1; w0 = 1'b0; a0 = 10'd1;
        v1 = 1'b1; w1 = 1'b0; a1 = 10'd2;
        idle(4);
        v0 = 1'b0; v1 = 1'b0;
        chk("alt_grants", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("alt_grant_id", 32'(glog[i]), 32'(i % 2));
        idle(4);

        // r1 alone three times, then a tie must go to r0.
        glog.delete();
        v1 = 1'b1; w1 = 1'b0; a1 = 10'd3;
        idle(3);
        v0 = 1'b1; w0 = 1'b0; a0 = 10'd4;
        tick();
        v0 = 1'b0; v1 = 1'b0;
        chk("solo_r1_grants", 32'(glog.size()), 32'd4);
        for (int i = 0; i < 3 && i < glog.size(); i++) chk("solo_r1_id", 32'(glog[i]), 32'd1);
        if (glog.size() > 3) chk("tie_after_r1", 32'(glog[3]), 32'd0);
        idle(4);

        // Clear with an r1 read accepted in the same cycle; second start mid-clear is ignored.
        req(1'b1, 1'b1, 10'd7, 32'h12345678);
        req(1'b1, 1'b1, 10'd1023, 32'hCAFEF00D);
        idle(2);
        v1 = 1'b1; w1 = 1'b0; a1 = 10'd7; cs = 1'b1;
        tick();
        chk("read_with_clear_acc", acc1, 1'b1);
        v1 = 1'b0; cs = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        v0 = 1'b1; w0 = 1'b0; a0 = 10'd0;
        for (int i = 0; i < 1030; i++) begin
            cs = (i == 500);
            tick();
            if (acc0) v0 = 1'b0;
        end
        cs = 1'b0; v0 = 1'b0;
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd1024);
        chk("clear_done_pulses", 32'(done_cnt), 32'd1);
        req(1'b0, 1'b0, 10'd0, 32'd0);
        req(1'b0, 1'b0, 10'd7, 32'd0);
        req(1'b1, 1'b0, 10'd1023, 32'd0);
        idle(4);
        chk("cleared_addr7_model", exp_mem[7], 32'd0);

        // Reset one cycle after a read acceptance: no response, r0 wins first tie.
        req(1'b0, 1'b1, 10'd9, 32'h99990000);
        req(1'b0, 1'b0, 10'd9, 32'd0);
        tick();
        do_reset();
        tick();
        v0 = 1'b1; w0 = 1'b0; a0 = 10'd9;
        v1 = 1'b1; w1 = 1'b0; a1 = 10'd9;
        tick();
        chk("post_reset_tie_r0", acc0, 1'b1);
        v0 = 1'b0; v1 = 1'b0;
        idle(5);

        // Randomized traffic with requesters honouring the hold rule.
        for (int i = 0; i < 1500; i++) begin
            if (!v0 || acc0) begin
                v0 = ($urandom_range(9) < 6);
                w0 = $urandom_range(1) == 1;
                a0 = 10'($urandom_range(15));
                d0 = $urandom;
            end
            if (!v1 || acc1) begin
                v1 = ($urandom_range(9) < 6);
                w1 = $urandom_range(1) == 1;
                a1 = 10'($urandom_range(15));
                d1 = $urandom;
            end
            tick();
        end
        v0 = 1'b0; v1 = 1'b0;
        idle(6);
        chk("resp_queue_drained", 32'(rq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
